// File: rtl/threshold_pkg.sv
// threshold_pkg: shared combine-mode type and bound reset values for multi_channel_threshold
package threshold_pkg;

    typedef enum logic {COMB_AND, COMB_OR} combine_t;

    // Wide enough for any sensible pixel width; users slice the low PIXEL_W bits
    localparam int MAX_BOUND_W = 64;
    localparam logic [MAX_BOUND_W-1:0] LOWER_RST = '0;
    localparam logic [MAX_BOUND_W-1:0] UPPER_RST = '1;

endpackage

// File: rtl/channel_compare.sv
// channel_compare: single-channel (lower, upper] band test with a registered result
module channel_compare #(
    parameter int PIXEL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic [PIXEL_W-1:0] pixel_i,
    input  logic [PIXEL_W-1:0] lower_i,
    input  logic [PIXEL_W-1:0] upper_i,
    output logic               in_band_o
);

    logic in_band_q;

    // Register the in-band flag, held low on idle beats so downstream sees clean zeros
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) in_band_q <= 1'b0;
        else in_band_q <= valid_i && (pixel_i > lower_i) && (pixel_i <= upper_i);

    assign in_band_o = in_band_q;

endmodule

// File: rtl/multi_channel_threshold.sv
// multi_channel_threshold: pipelined per-channel band threshold with combine, invert and frame mask count
module multi_channel_threshold
    import threshold_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int NUM_CH  = 3,
    parameter int COUNT_W = 20,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pixel_valid_in,
    input  logic [NUM_CH*PIXEL_W-1:0] pixel_in,
    input  logic                      sof_in,
    input  logic                      eof_in,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [PIXEL_W-1:0]        cfg_lower,
    input  logic [PIXEL_W-1:0]        cfg_upper,
    input  logic                      cfg_mode_we,
    input  logic                      cfg_combine,
    input  logic                      cfg_invert,
    output logic                      mask_valid_out,
    output logic                      mask_out,
    output logic [NUM_CH-1:0]         ch_mask_out,
    output logic                      sof_out,
    output logic                      eof_out,
    output logic [COUNT_W-1:0]        count_out,
    output logic                      count_valid
);

    localparam logic [PIXEL_W-1:0] LO_RST = LOWER_RST[PIXEL_W-1:0];
    localparam logic [PIXEL_W-1:0] HI_RST = UPPER_RST[PIXEL_W-1:0];

    logic              sof_beat;
    logic [NUM_CH-1:0] ch1;
    combine_t          stg_comb_q, act_comb_q, comb1_q;
    logic              stg_inv_q, act_inv_q, inv1_q;
    logic              v1_q, sof1_q, eof1_q;
    logic              v2_q, sof2_q, eof2_q, mask2_q;
    logic [NUM_CH-1:0] ch2_q;
    logic              comb_raw;
    logic [COUNT_W-1:0] acc_q, acc_d, count_q;
    logic              count_v_q;

    assign sof_beat = pixel_valid_in && sof_in;

    // Mode staging takes cfg writes; active copies staging on each accepted SOF
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stg_comb_q <= COMB_AND;
            stg_inv_q  <= 1'b0;
            act_comb_q <= COMB_AND;
            act_inv_q  <= 1'b0;
        end else begin
            if (cfg_mode_we) begin
                stg_comb_q <= combine_t'(cfg_combine);
                stg_inv_q  <= cfg_invert;
            end
            if (sof_beat) begin
                act_comb_q <= stg_comb_q;
                act_inv_q  <= stg_inv_q;
            end
        end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PIXEL_W-1:0] stg_lo_q, stg_hi_q, act_lo_q, act_hi_q;
        logic               sel;
        assign sel = cfg_we && (cfg_ch == CH_W'(c));
        // Per-channel bound shadowing; the SOF pixel itself sees staging directly
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                stg_lo_q <= LO_RST;
                stg_hi_q <= HI_RST;
                act_lo_q <= LO_RST;
                act_hi_q <= HI_RST;
            end else begin
                if (sel) begin
                    stg_lo_q <= cfg_lower;
                    stg_hi_q <= cfg_upper;
                end
                if (sof_beat) begin
                    act_lo_q <= stg_lo_q;
                    act_hi_q <= stg_hi_q;
                end
            end
        channel_compare #(.PIXEL_W(PIXEL_W)) u_cmp (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid_i   (pixel_valid_in),
            .pixel_i   (pixel_in[c*PIXEL_W +: PIXEL_W]),
            .lower_i   (sof_beat ? stg_lo_q : act_lo_q),
            .upper_i   (sof_beat ? stg_hi_q : act_hi_q),
            .in_band_o (ch1[c])
        );
    end

    // Stage 1 sideband: carries the mode in force for each pixel alongside its compare
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sof1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            comb1_q <= COMB_AND;
            inv1_q  <= 1'b0;
        end else begin
            v1_q    <= pixel_valid_in;
            sof1_q  <= sof_beat;
            eof1_q  <= pixel_valid_in && eof_in;
            comb1_q <= sof_beat ? stg_comb_q : act_comb_q;
            inv1_q  <= sof_beat ? stg_inv_q : act_inv_q;
        end

    assign comb_raw = (comb1_q == COMB_OR) ? |ch1 : &ch1;

    // Stage 2: combine/invert and forward sideband; mask forced low on idle beats
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v2_q    <= 1'b0;
            sof2_q  <= 1'b0;
            eof2_q  <= 1'b0;
            ch2_q   <= '0;
            mask2_q <= 1'b0;
        end else begin
            v2_q    <= v1_q;
            sof2_q  <= sof1_q;
            eof2_q  <= eof1_q;
            ch2_q   <= ch1;
            mask2_q <= v1_q && (comb_raw ^ inv1_q);
        end

    // Saturating frame accumulator fed by stage-2 beats; SOF restarts from this beat's mask
    always_comb begin
        acc_d = acc_q;
        if (v2_q)
            acc_d = sof2_q ? COUNT_W'(mask2_q) : (&acc_q ? acc_q : acc_q + COUNT_W'(mask2_q));
    end

    // Publish the final accumulator the cycle after a stage-2 EOF
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc_q     <= '0;
            count_q   <= '0;
            count_v_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            count_v_q <= v2_q && eof2_q;
            if (v2_q && eof2_q) count_q <= acc_d;
        end

    assign mask_valid_out = v2_q;
    assign mask_out       = mask2_q;
    assign ch_mask_out    = ch2_q;
    assign sof_out        = sof2_q;
    assign eof_out        = eof2_q;
    assign count_out      = count_q;
    assign count_valid    = count_v_q;

endmodule

// File: doc/multi_channel_threshold.md
# multi_channel_threshold

Parametrised, pipelined band-threshold for multi-channel pixel streams (e.g. RGB or YCrCb). Each channel is tested against its own (lower, upper] interval; the per-channel results are combined (AND/OR, optional invert) into a 1-bit mask. It also produces a per-frame count of mask pixels. Sits between the pixel source / colour-space converter and the centroid / mask-consumer stages. Bounds are double-buffered so configuration never tears mid-frame.

## Interface
- PIXEL_W, 8, bits per channel
- NUM_CH, 3, channel count (≥1)
- COUNT_W, 20, mask-count width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pixel_valid_in  in  1  pixel beat valid
- pixel_in  in  NUM_CH*PIXEL_W  channel c at bits [c*PIXEL_W +: PIXEL_W]
- sof_in  in  1  first pixel of frame; qualified by pixel_valid_in
- eof_in  in  1  last pixel of frame; qualified by pixel_valid_in
- cfg_we  in  1  write staging bounds for cfg_ch
- cfg_ch  in  max(1,$clog2(NUM_CH))  channel index; writes with cfg_ch ≥ NUM_CH are ignored
- cfg_lower, cfg_upper  in  PIXEL_W each  staging bounds
- cfg_mode_we  in  1  write staging mode
- cfg_combine  in  1  0 = AND, 1 = OR
- cfg_invert  in  1  invert combined mask
- mask_valid_out  out  1  output beat valid
- mask_out  out  1  combined mask
- ch_mask_out  out  NUM_CH  per-channel in-band flags, before combine/invert
- sof_out, eof_out  out  1 each  delayed sideband
- count_out  out  COUNT_W  mask-pixel count of the last completed frame
- count_valid  out  1  one-cycle pulse when count_out updates

## Operation
- Per channel: in-band = (pixel > lower) && (pixel <= upper), unsigned. lower ≥ upper yields 0.
- Combine: AND or OR across channels. Invert is applied after combine. ch_mask_out is never inverted.
- Staging registers (bounds per channel, mode) are written by cfg_we / cfg_mode_we on any cycle.
- Active registers copy all staging values on an accepted SOF beat (pixel_valid_in && sof_in). That SOF pixel uses the new values.
- A cfg write in the same cycle as an SOF beat lands in staging only. It becomes active at the next SOF.
- Reset values:
  - staging and active lower = 0, upper = all ones, combine = AND, invert = 0.
  - All outputs 0, including count_out and count_valid.
- Accumulator:
  - Loads 0 + mask on the stage-2 SOF beat.
  - Adds mask on other valid beats.
  - Saturates at 2^COUNT_W−1.
- Stage-2 EOF beat:
  - The next cycle, count_out = final accumulator value, including the EOF beat, and count_valid = 1 for exactly one cycle.
  - count_out holds until the next EOF.
- Single-pixel frame (sof and eof on the same beat): count_out = that beat's mask.
- EOF with no prior SOF since reset: accumulation runs from 0 (reset value).
- Invalid beats: sof_in / eof_in are ignored, no count change, mask_valid_out = 0.
- Reset mid-frame: pipeline, accumulator, and active/staging registers all return to reset values immediately.

## Timing
- Latency is 2 cycles from pixel beat to mask_valid_out / mask_out / ch_mask_out / sof_out / eof_out.
  - Stage 1: registered per-channel compare plus sideband.
  - Stage 2: registered combine/invert.
- Full throughput: one beat per cycle, no backpressure, no bubbles inserted.
- count_valid asserts 1 cycle after eof_out, i.e. 3 cycles after the EOF input beat.
- mask_out and ch_mask_out are 0 whenever mask_valid_out = 0.

## Structure
- Package threshold_pkg holds:
  - typedef enum logic {COMB_AND, COMB_OR} combine_t
  - bound-reset constants (lower 0, upper '1 as a function of width)
- Sub-module channel_compare: one PIXEL_W band compare with a registered output, instantiated NUM_CH times via generate.
- Top level holds the staging/active registers, combine stage, sideband pipe, and accumulator.

## Test plan
- Reset defaults, NUM_CH=3, PIXEL_W=8:
  - pixels (0,5,5) → mask 0, ch_mask 3'b110
  - pixels (1,1,255) → mask 1, two cycles after input
- Band edges: ch0 bounds (10,20], AND mode, other channels at defaults with nonzero inputs.
  - ch0 = 10 → 0; 11 → 1; 20 → 1; 21 → 0
  - cfg_invert = 1 → each result flipped
- Shadowing:
  - Write ch0 = (100,200] mid-frame → remaining pixels still use old bounds.
  - Write in the same cycle as the next SOF → not applied to that frame.
  - Applied at the following SOF.
- Count: 8-pixel frame with 5 mask pixels → count_out = 5, count_valid a single pulse 3 cycles after the EOF input.
  - Single-pixel SOF+EOF frame with mask 1 → count_out = 1.
- Saturation: COUNT_W=3, frame of 10 mask pixels → count_out = 7.
- rst_n asserted mid-frame → all outputs 0 asynchronously.
  - After release, bounds are back to defaults and the next frame counts from 0.
